// File: rtl/axi_ram_slave_pkg.sv
// Shared encodings for axi_ram_slave: FSM states, AXI response/burst/size constants.
package axi_ram_slave_pkg;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'b00,
    W_DATA = 2'b01,
    W_RESP = 2'b10
  } w_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [2:0] SIZE_WORD   = 3'b010;

  // Anything other than a 32-bit INCR burst is outside what this RAM models.
  function automatic logic bad_burst(input logic [2:0] size, input logic [1:0] burst);
    return (size != SIZE_WORD) || (burst != BURST_INCR);
  endfunction

endpackage

// File: rtl/axi_ram_mem.sv
// Word-wide RAM: one registered synchronous read port, one byte-enabled write port.
module axi_ram_mem
  import axi_ram_slave_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [31:0]       rd_data_o,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [31:0]       wr_data_i,
  input  logic [3:0]        wr_strb_i
);

  logic [31:0] mem_q [2**ADDR_W];
  logic [31:0] rd_data_q;

  // Contents are never reset; only the read register is.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb_i[b]) mem_q[wr_addr_i][8*b +: 8] <= wr_data_i[8*b +: 8];
      end
    end
  end

  // Read samples the pre-write contents, so a same-word collision returns old data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       rd_data_q <= '0;
    else if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/axi_ram_slave.sv
// AXI RAM slave with independent read and write burst FSMs over axi_ram_mem.
// Define AXI_RAM_SLAVE_CHK_EN to answer non-word or non-INCR bursts with SLVERR.
module axi_ram_slave
  import axi_ram_slave_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  axis_arid,
  input  logic [31:0] axis_araddr,
  input  logic [3:0]  axis_arlen,
  input  logic [2:0]  axis_arsize,
  input  logic [1:0]  axis_arburst,
  input  logic        axis_arvalid,
  output logic        axis_arready,
  output logic [3:0]  axis_rid,
  output logic [31:0] axis_rdata,
  output logic [1:0]  axis_rresp,
  output logic        axis_rlast,
  output logic        axis_rvalid,
  input  logic        axis_rready,
  input  logic [3:0]  axis_awid,
  input  logic [31:0] axis_awaddr,
  input  logic [3:0]  axis_awlen,
  input  logic [2:0]  axis_awsize,
  input  logic [1:0]  axis_awburst,
  input  logic        axis_awvalid,
  output logic        axis_awready,
  input  logic [3:0]  axis_wid,
  input  logic [31:0] axis_wdata,
  input  logic [3:0]  axis_wstrb,
  input  logic        axis_wlast,
  input  logic        axis_wvalid,
  output logic        axis_wready,
  output logic [3:0]  axis_bid,
  output logic [1:0]  axis_bresp,
  output logic        axis_bvalid,
  input  logic        axis_bready,
  output logic        dbg_r_state_o,
  output logic [1:0]  dbg_w_state_o
);

  // valid/ready: a beat transfers on a rising edge where both are 1; the source
  // keeps valid and payload stable until then, and ready never waits on valid.

  r_state_e          r_state_q;
  logic              arready_q, rvalid_q, rlast_q, r_err_q;
  logic [3:0]        rid_q, rlen_q, rcnt_q;
  logic [1:0]        rresp_q;
  logic [ADDR_W-1:0] raddr_q;

  w_state_e          w_state_q;
  logic              awready_q, wready_q, bvalid_q, w_err_q;
  logic [3:0]        bid_q, wlen_q, wcnt_q;
  logic [1:0]        bresp_q;
  logic [ADDR_W-1:0] waddr_q;

  logic              ar_hs, r_hs, aw_hs, w_hs, r_bad, w_bad;
  logic              mem_rd_en, mem_wr_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [31:0]       mem_rd_data;

`ifdef AXI_RAM_SLAVE_CHK_EN
  logic unused_ok;
  assign r_bad     = bad_burst(axis_arsize, axis_arburst);
  assign w_bad     = bad_burst(axis_awsize, axis_awburst);
  assign unused_ok = ^{axis_wid, axis_araddr[31:ADDR_W+2], axis_araddr[1:0],
                       axis_awaddr[31:ADDR_W+2], axis_awaddr[1:0]};
`else
  logic unused_ok;
  assign r_bad     = 1'b0;
  assign w_bad     = 1'b0;
  assign unused_ok = ^{axis_wid, axis_arsize, axis_arburst, axis_awsize, axis_awburst,
                       axis_araddr[31:ADDR_W+2], axis_araddr[1:0],
                       axis_awaddr[31:ADDR_W+2], axis_awaddr[1:0]};
`endif

  assign ar_hs = axis_arvalid && arready_q;
  assign r_hs  = rvalid_q && axis_rready;
  assign aw_hs = axis_awvalid && awready_q;
  assign w_hs  = axis_wvalid && wready_q;

  // Read only when a new beat is due, so rdata stays put while the master stalls.
  assign mem_rd_en   = ar_hs || (r_hs && !rlast_q);
  assign mem_rd_addr = (r_state_q == R_IDLE) ? axis_araddr[ADDR_W+1:2] : raddr_q + 1'b1;
  assign mem_wr_en   = w_hs && !w_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      r_err_q   <= 1'b0;
      rid_q     <= '0;
      rlen_q    <= '0;
      rcnt_q    <= '0;
      rresp_q   <= RESP_OKAY;
      raddr_q   <= '0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          arready_q <= 1'b1;
          if (ar_hs) begin
            r_state_q <= R_DATA;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rid_q     <= axis_arid;
            rlen_q    <= axis_arlen;
            rcnt_q    <= '0;
            raddr_q   <= axis_araddr[ADDR_W+1:2];
            rlast_q   <= (axis_arlen == 4'd0);
            r_err_q   <= r_bad;
            rresp_q   <= r_bad ? RESP_SLVERR : RESP_OKAY;
          end
        end
        R_DATA: begin
          if (r_hs) begin
            if (rlast_q) begin
              r_state_q <= R_IDLE;
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              arready_q <= 1'b1;
            end else begin
              rcnt_q  <= rcnt_q + 4'd1;
              raddr_q <= raddr_q + 1'b1;
              rlast_q <= (rcnt_q + 4'd1 == rlen_q);
            end
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      w_err_q   <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= RESP_OKAY;
      wlen_q    <= '0;
      wcnt_q    <= '0;
      waddr_q   <= '0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          awready_q <= 1'b1;
          if (aw_hs) begin
            w_state_q <= W_DATA;
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            bid_q     <= axis_awid;
            wlen_q    <= axis_awlen;
            wcnt_q    <= '0;
            waddr_q   <= axis_awaddr[ADDR_W+1:2];
            w_err_q   <= w_bad;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            waddr_q <= waddr_q + 1'b1;
            wcnt_q  <= wcnt_q + 4'd1;
            if (axis_wlast) begin
              w_state_q <= W_RESP;
              wready_q  <= 1'b0;
              bvalid_q  <= 1'b1;
              bresp_q   <= (w_err_q || (wcnt_q != wlen_q)) ? RESP_SLVERR : RESP_OKAY;
            end
          end
        end
        W_RESP: begin
          if (axis_bready) begin
            w_state_q <= W_IDLE;
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  axi_ram_mem #(.ADDR_W(ADDR_W)) u_mem (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_en_i   (mem_rd_en),
    .rd_addr_i (mem_rd_addr),
    .rd_data_o (mem_rd_data),
    .wr_en_i   (mem_wr_en),
    .wr_addr_i (waddr_q),
    .wr_data_i (axis_wdata),
    .wr_strb_i (axis_wstrb)
  );

  assign axis_arready  = arready_q;
  assign axis_rvalid   = rvalid_q;
  assign axis_rlast    = rlast_q;
  assign axis_rid      = rid_q;
  assign axis_rresp    = rresp_q;
  assign axis_rdata    = r_err_q ? 32'h0 : mem_rd_data;
  assign axis_awready  = awready_q;
  assign axis_wready   = wready_q;
  assign axis_bvalid   = bvalid_q;
  assign axis_bid      = bid_q;
  assign axis_bresp    = bresp_q;
  assign dbg_r_state_o = r_state_q;
  assign dbg_w_state_o = w_state_q;

endmodule

// File: doc/axi_ram_slave.md
AXI_RAM_SLAVE -- requirements
Module: axi_ram_slave

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 12, giving the word-address width; memory depth is 2^ADDR_W 32-bit words.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all logic is rising-edge clocked.
REQ-003 The block SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 The block SHALL have read-address ports axis_arid/araddr/arlen/arsize/arburst/arvalid, input, 4/32/4/3/2/1, and axis_arready, output, 1.
REQ-005 The block SHALL have read-data ports axis_rid/rdata/rresp/rlast/rvalid, output, 4/32/2/1/1, and axis_rready, input, 1.
REQ-006 The block SHALL have write-address ports axis_awid/awaddr/awlen/awsize/awburst/awvalid, input, 4/32/4/3/2/1, and axis_awready, output, 1.
REQ-007 The block SHALL have write-data ports axis_wid/wdata/wstrb/wlast/wvalid, input, 4/32/4/1/1, and axis_wready, output, 1.
REQ-008 The block SHALL have write-response ports axis_bid/bresp/bvalid, output, 4/2/1, and axis_bready, input, 1.

Function
REQ-009 The read FSM SHALL have states R_IDLE and R_DATA; axis_arready=1 only in R_IDLE.
REQ-010 On an AR handshake the block SHALL latch arid, arlen and word address araddr[ADDR_W+1:2], then enter R_DATA.
REQ-011 The first R beat SHALL be valid in the cycle after the AR handshake, with rdata registered from memory.
REQ-012 While rvalid=1 and rready=0, rdata, rid, rresp and rlast SHALL hold stable.
REQ-013 On each R handshake the word address SHALL increment modulo 2^ADDR_W and the beat counter by 1.
REQ-014 rlast SHALL be 1 exactly when beat count equals latched arlen; its handshake returns the FSM to R_IDLE.
REQ-015 rid SHALL echo the latched arid; rresp SHALL be OKAY (2'b00) unless REQ-024 applies.
REQ-016 The write FSM SHALL have states W_IDLE, W_DATA and W_RESP; axis_awready=1 only in W_IDLE; axis_wready=1 only in W_DATA.
REQ-017 Each W handshake SHALL write only the bytes enabled in wstrb to the current word, then increment the address modulo 2^ADDR_W.
REQ-018 A W handshake with wlast=1 SHALL move the FSM to W_RESP; bresp SHALL be SLVERR (2'b10) if beat count differs from awlen at wlast, else OKAY.
REQ-019 In W_RESP bvalid=1 with bid=latched awid, held until bready; the FSM then returns to W_IDLE.
REQ-020 Read and write channels SHALL operate concurrently; a read and write to the same word in one cycle SHALL return the old data.
REQ-021 arsize, awsize and arburst/awburst SHALL be ignored (word INCR assumed) unless REQ-024 applies; wid is ignored.

Reset
REQ-022 While rst_n=0, all outputs SHALL be 0, both FSMs idle, counters cleared; arready/awready SHALL rise on the first clk edge after release.
REQ-023 Reset mid-burst SHALL abandon the burst without a response; memory contents SHALL NOT be reset.

Configuration
REQ-024 With macro AXI_RAM_SLAVE_CHK_EN defined, a burst with size!=3'b010 or burst!=INCR SHALL complete all beats with SLVERR: reads return rdata=0, writes are suppressed. Without the macro, REQ-021 applies and no checking logic exists.

Structure
REQ-025 A shared package/header SHALL hold FSM state encodings, RESP_OKAY/RESP_SLVERR, BURST_INCR and SIZE_WORD constants.
REQ-026 The memory SHALL be a sub-module axi_ram_mem: 1 synchronous read port, 1 byte-enabled write port, depth 2^ADDR_W.

Verification
REQ-027 Preload mem[i]=i, AR addr 0x40 len 0xF id 3 -> 16 beats rdata 0x10..0x1F, rlast on beat 16 only, rid=3, rresp=0.
REQ-028 AW addr 0x100 len 3 id 5; beat 2 wstrb=4'b0011 data 0xAAAABBBB -> mem[0x41] low half 0xBBBB, upper half unchanged; bresp=0, bid=5, bvalid held until bready.
REQ-029 Drop rready for 3 cycles mid-burst -> R outputs stable, no beat lost or repeated.
REQ-030 ADDR_W=12, araddr 0x3FFC len 1 -> beats mem[4095] then mem[0].
REQ-031 awlen 3 with wlast on beat 2 -> bresp=SLVERR; with AXI_RAM_SLAVE_CHK_EN, arsize=0 -> all R beats SLVERR, rdata=0.
REQ-032 Pull rst_n low mid-read -> rvalid=0 immediately; one cycle after release arready=1 and a new burst reads correctly.
